// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, keeps one program-memory read in flight and hands each instruction to execute over valid/ready.
// Define IFU_PERF_CNT_EN to add the fetch_count / discard_count performance counters.
module instr_fetch_unit #(
  parameter int              PC_W        = 16,
  parameter logic [PC_W-1:0] RESET_PC    = '0,
  parameter logic [4:0]      HALT_OPCODE = 5'd27
) (
  input  logic            clk,
  input  logic            sys_rst_n,
  output logic            mem_req,
  output logic [PC_W-1:0] mem_addr,
  input  logic            mem_rvalid,
  input  logic [31:0]     mem_rdata,
  output logic            ir_valid,
  input  logic            ir_ready,
  output logic [31:0]     ir_data,
  output logic [PC_W-1:0] ir_pc,
  input  logic            jmp_en,
  input  logic [PC_W-1:0] jmp_addr,
  input  logic            resume,
  output logic            halted
`ifdef IFU_PERF_CNT_EN
  ,
  output logic [31:0]     fetch_count,
  output logic [15:0]     discard_count
`endif
);

  localparam logic [PC_W-1:0] PC_ONE = 1;

  typedef enum logic [1:0] {
    ST_FETCH,
    ST_WAIT,
    ST_HOLD,
    ST_HALTED
  } state_t;

  state_t          state;
  logic [PC_W-1:0] pc;
  logic            discard;

  logic            handshake;
  logic            is_halt;
  logic [PC_W-1:0] redirect_pc;
  logic [PC_W-1:0] accept_pc;

  always_comb begin
    handshake   = ir_valid && ir_ready;
    is_halt     = (ir_data[31:27] == HALT_OPCODE);
    redirect_pc = jmp_en ? jmp_addr : pc;
    accept_pc   = jmp_en ? jmp_addr : (pc + PC_ONE);
  end

  // mem_req is high exactly during FETCH cycles, so every transition into
  // FETCH also loads the request and its address. The only FETCH cycle without
  // a request is the first one after reset, which just arms it.
  always_ff @(posedge clk) begin
    if (!sys_rst_n) begin
      state    <= ST_FETCH;
      pc       <= RESET_PC;
      discard  <= 1'b0;
      mem_req  <= 1'b0;
      mem_addr <= RESET_PC;
      ir_valid <= 1'b0;
      ir_data  <= '0;
      ir_pc    <= RESET_PC;
      halted   <= 1'b0;
    end else begin
      mem_req <= 1'b0;
      if (jmp_en) pc <= jmp_addr;

      case (state)
        ST_FETCH: begin
          if (mem_req) begin
            state   <= ST_WAIT;
            discard <= jmp_en;
          end else begin
            mem_req  <= 1'b1;
            mem_addr <= redirect_pc;
          end
        end

        ST_WAIT: begin
          if (mem_rvalid) begin
            if (discard || jmp_en) begin
              discard  <= 1'b0;
              state    <= ST_FETCH;
              mem_req  <= 1'b1;
              mem_addr <= redirect_pc;
            end else begin
              ir_data  <= mem_rdata;
              ir_pc    <= pc;
              ir_valid <= 1'b1;
              state    <= ST_HOLD;
            end
          end else if (jmp_en) begin
            discard <= 1'b1;
          end
        end

        ST_HOLD: begin
          if (handshake) begin
            ir_valid <= 1'b0;
            pc       <= accept_pc;
            if (is_halt) begin
              halted <= 1'b1;
              state  <= ST_HALTED;
            end else begin
              state    <= ST_FETCH;
              mem_req  <= 1'b1;
              mem_addr <= accept_pc;
            end
          end else if (jmp_en) begin
            ir_valid <= 1'b0;
            state    <= ST_FETCH;
            mem_req  <= 1'b1;
            mem_addr <= jmp_addr;
          end
        end

        ST_HALTED: begin
          if (resume) begin
            halted   <= 1'b0;
            state    <= ST_FETCH;
            mem_req  <= 1'b1;
            mem_addr <= redirect_pc;
          end
        end

        default: state <= ST_FETCH;
      endcase
    end
  end

`ifdef IFU_PERF_CNT_EN
  logic drop_evt;

  // A drop is a response thrown away in WAIT or an unaccepted instruction flushed from HOLD.
  always_comb begin
    drop_evt = 1'b0;
    if (state == ST_WAIT && mem_rvalid && (discard || jmp_en)) drop_evt = 1'b1;
    if (state == ST_HOLD && jmp_en && !handshake) drop_evt = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!sys_rst_n) begin
      fetch_count   <= '0;
      discard_count <= '0;
    end else begin
      if (handshake && fetch_count != 32'hFFFF_FFFF) fetch_count <= fetch_count + 32'd1;
      if (drop_evt && discard_count != 16'hFFFF) discard_count <= discard_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: behavioural memory with programmable latency plus request/instruction scoreboards.
// Build with IFU_PERF_CNT_EN defined to also check the performance counters.
module tb_instr_fetch_unit;

  localparam int PC_W = 16;

  typedef struct {
    logic [31:0]     data;
    logic [PC_W-1:0] pc;
  } ir_exp_t;

  logic            clk;
  logic            sys_rst_n;
  logic            mem_req;
  logic [PC_W-1:0] mem_addr;
  logic            mem_rvalid;
  logic [31:0]     mem_rdata;
  logic            ir_valid;
  logic            ir_ready;
  logic [31:0]     ir_data;
  logic [PC_W-1:0] ir_pc;
  logic            jmp_en;
  logic [PC_W-1:0] jmp_addr;
  logic            resume;
  logic            halted;
`ifdef IFU_PERF_CNT_EN
  logic [31:0]     fetch_count;
  logic [15:0]     discard_count;
`endif

  int vec_count   = 0;
  int miscompares = 0;
  int cyc         = 0;
  int hs_count    = 0;
  int mem_lat     = 1;
  logic halt_en   = 1'b0;

  logic [PC_W-1:0] req_q[$];
  ir_exp_t         ir_q[$];
  int              hs_cyc[$];

  instr_fetch_unit #(
    .PC_W(PC_W),
    .RESET_PC(16'h0000),
    .HALT_OPCODE(5'd27)
  ) dut (
    .clk(clk),
    .sys_rst_n(sys_rst_n),
    .mem_req(mem_req),
    .mem_addr(mem_addr),
    .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata),
    .ir_valid(ir_valid),
    .ir_ready(ir_ready),
    .ir_data(ir_data),
    .ir_pc(ir_pc),
    .jmp_en(jmp_en),
    .jmp_addr(jmp_addr),
    .resume(resume),
    .halted(halted)
`ifdef IFU_PERF_CNT_EN
    ,
    .fetch_count(fetch_count),
    .discard_count(discard_count)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [31:0] mem_word(input logic [PC_W-1:0] a);
    if (halt_en && a == 16'd3) return {5'd27, 11'd0, a};
    return 32'h1000_0000 | {16'h0000, a};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vec_count++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", tag, observed, expected, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic jmp, input logic [PC_W-1:0] addr, input logic res, input logic rdy);
    jmp_en   = jmp;
    jmp_addr = addr;
    resume   = res;
    ir_ready = rdy;
  endtask

  task automatic pushIr(input logic [31:0] d, input logic [PC_W-1:0] p);
    ir_exp_t e;
    e.data = d;
    e.pc   = p;
    ir_q.push_back(e);
  endtask

  // Memory model: samples a request at the edge, answers mem_lat cycles after the request cycle.
  initial begin
    logic            req_s;
    logic            rst_s;
    logic [PC_W-1:0] addr_s;
    logic            busy;
    int              cnt;
    logic [PC_W-1:0] addr_q;
    mem_rvalid = 1'b0;
    mem_rdata  = '0;
    busy       = 1'b0;
    cnt        = 0;
    addr_q     = '0;
    forever begin
      @(posedge clk);
      req_s  = mem_req;
      addr_s = mem_addr;
      rst_s  = sys_rst_n;
      #1;
      mem_rvalid = 1'b0;
      if (!rst_s) begin
        busy = 1'b0;
      end else begin
        if (req_s) begin
          busy   = 1'b1;
          cnt    = mem_lat;
          addr_q = addr_s;
        end
        if (busy) begin
          if (cnt <= 1) begin
            mem_rvalid = 1'b1;
            mem_rdata  = mem_word(addr_q);
            busy       = 1'b0;
          end else begin
            cnt--;
          end
        end
      end
    end
  end

  // Scoreboard side: every request and every accepted instruction must match the next queued expectation.
  initial begin
    ir_exp_t e;
    forever begin
      @(negedge clk);
      cyc++;
      if (sys_rst_n && mem_req) begin
        if (req_q.size() == 0) checkOutput("req_extra", 32'(mem_req), 32'd0);
        else checkOutput("mem_addr", 32'(mem_addr), 32'(req_q.pop_front()));
      end
      if (sys_rst_n && ir_valid && ir_ready) begin
        hs_count++;
        hs_cyc.push_back(cyc);
        if (ir_q.size() == 0) begin
          checkOutput("ir_extra", 32'(ir_valid), 32'd0);
        end else begin
          e = ir_q.pop_front();
          checkOutput("ir_data", ir_data, e.data);
          checkOutput("ir_pc", 32'(ir_pc), 32'(e.pc));
        end
      end
    end
  end

  task automatic doReset();
    sys_rst_n = 1'b0;
    applyStimulus(1'b0, '0, 1'b0, 1'b0);
    halt_en = 1'b0;
    tick();
    tick();
    req_q.delete();
    ir_q.delete();
    hs_cyc.delete();
    hs_count = 0;
    checkOutput("rst_mem_req", 32'(mem_req), 32'd0);
    checkOutput("rst_mem_addr", 32'(mem_addr), 32'd0);
    checkOutput("rst_ir_valid", 32'(ir_valid), 32'd0);
    checkOutput("rst_ir_data", ir_data, 32'd0);
    checkOutput("rst_ir_pc", 32'(ir_pc), 32'd0);
    checkOutput("rst_halted", 32'(halted), 32'd0);
    sys_rst_n = 1'b1;
  endtask

  task automatic waitHs(input int target, input string tag);
    for (int n = 0; n < 300; n++) begin
      tick();
      if (hs_count >= target) break;
    end
    checkOutput(tag, 32'(hs_count >= target), 32'd1);
  endtask

  task automatic waitValid(input string tag);
    for (int n = 0; n < 100; n++) begin
      if (ir_valid) break;
      tick();
    end
    checkOutput(tag, 32'(ir_valid), 32'd1);
  endtask

  task automatic endTest(input string tag);
    checkOutput({tag, "_req_left"}, 32'(req_q.size()), 32'd0);
    checkOutput({tag, "_ir_left"}, 32'(ir_q.size()), 32'd0);
  endtask

  initial begin
    sys_rst_n = 1'b0;
    applyStimulus(1'b0, '0, 1'b0, 1'b0);

    // Streaming with a 1-cycle memory, then a stall in HOLD, then jump coinciding with a handshake.
    mem_lat = 1;
    doReset();
    for (int i = 0; i < 4; i++) begin
      req_q.push_back(PC_W'(i));
      pushIr(32'h1000_0000 + 32'(i), PC_W'(i));
    end
    checkOutput("release_no_req", 32'(mem_req), 32'd0);
    ir_ready = 1'b1;
    tick();
    checkOutput("first_req", 32'(mem_req), 32'd1);
    waitHs(3, "t1_hs_timeout");
    ir_ready = 1'b0;
    checkOutput("tput_0_1", 32'(hs_cyc[1] - hs_cyc[0]), 32'd3);
    checkOutput("tput_1_2", 32'(hs_cyc[2] - hs_cyc[1]), 32'd3);

    waitValid("t2_valid_timeout");
    for (int i = 0; i < 5; i++) begin
      checkOutput("stall_valid", 32'(ir_valid), 32'd1);
      checkOutput("stall_data", ir_data, 32'h1000_0003);
      checkOutput("stall_no_req", 32'(mem_req), 32'd0);
      tick();
    end
    req_q.push_back(16'd4);
    req_q.push_back(16'd5);
    pushIr(32'h1000_0004, 16'd4);
    pushIr(32'h1000_0005, 16'd5);
    ir_ready = 1'b1;
    for (int n = 0; n < 50; n++) begin
      if (ir_valid && ir_pc == 16'd5) break;
      tick();
    end
    checkOutput("t4_pc5_timeout", 32'(ir_valid && ir_pc == 16'd5), 32'd1);
    req_q.push_back(16'h0010);
    applyStimulus(1'b1, 16'h0010, 1'b0, 1'b1);
    tick();
    applyStimulus(1'b0, '0, 1'b0, 1'b0);
    waitValid("t4_valid_timeout");
    checkOutput("jmp_hs_ir_pc", 32'(ir_pc), 32'h0000_0010);
    checkOutput("jmp_hs_ir_data", ir_data, 32'h1000_0010);
    checkOutput("jmp_hs_count", 32'(hs_count), 32'd6);
`ifdef IFU_PERF_CNT_EN
    checkOutput("t1_fetch_count", fetch_count, 32'd6);
    checkOutput("t1_discard_count", 32'(discard_count), 32'd0);
`endif
    endTest("t1");

    // Redirect while a 3-cycle read is outstanding: the stale word must never reach execute.
    mem_lat = 3;
    doReset();
    req_q.push_back(16'h0000);
    req_q.push_back(16'h0040);
    tick();
    tick();
    applyStimulus(1'b1, 16'h0040, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, '0, 1'b0, 1'b0);
    waitValid("t3_valid_timeout");
    checkOutput("wait_jmp_ir_pc", 32'(ir_pc), 32'h0000_0040);
    checkOutput("wait_jmp_ir_data", ir_data, 32'h1000_0040);
`ifdef IFU_PERF_CNT_EN
    checkOutput("t3_discard_count", 32'(discard_count), 32'd1);
    checkOutput("t3_fetch_count", fetch_count, 32'd0);
`endif
    endTest("t3");

    // HALT at address 3, ten idle cycles, then resume continues at 4.
    mem_lat = 1;
    doReset();
    halt_en = 1'b1;
    for (int i = 0; i < 4; i++) req_q.push_back(PC_W'(i));
    pushIr(32'h1000_0000, 16'd0);
    pushIr(32'h1000_0001, 16'd1);
    pushIr(32'h1000_0002, 16'd2);
    pushIr({5'd27, 11'd0, 16'd3}, 16'd3);
    ir_ready = 1'b1;
    for (int n = 0; n < 60; n++) begin
      if (halted) break;
      tick();
    end
    checkOutput("halt_seen", 32'(halted), 32'd1);
    for (int i = 0; i < 10; i++) begin
      tick();
      checkOutput("halt_stays", 32'(halted), 32'd1);
      checkOutput("halt_no_req", 32'(mem_req), 32'd0);
    end
    req_q.push_back(16'd4);
    applyStimulus(1'b0, '0, 1'b1, 1'b0);
    tick();
    applyStimulus(1'b0, '0, 1'b0, 1'b0);
    checkOutput("resume_clears", 32'(halted), 32'd0);
    waitValid("t5_valid_timeout");
    checkOutput("resume_ir_pc", 32'(ir_pc), 32'd4);
    checkOutput("resume_ir_data", ir_data, 32'h1000_0004);
    endTest("t5");

    // Jump issued in a FETCH cycle to the top address; the PC must wrap to 0.
    doReset();
    req_q.push_back(16'h0000);
    req_q.push_back(16'hFFFF);
    req_q.push_back(16'h0000);
    pushIr(32'h1000_FFFF, 16'hFFFF);
    tick();
    checkOutput("wrap_first_req", 32'(mem_req), 32'd1);
    applyStimulus(1'b1, 16'hFFFF, 1'b0, 1'b1);
    tick();
    applyStimulus(1'b0, '0, 1'b0, 1'b1);
    waitHs(1, "t6_hs_timeout");
    ir_ready = 1'b0;
    waitValid("t6_valid_timeout");
    checkOutput("wrap_ir_pc", 32'(ir_pc), 32'd0);
    checkOutput("wrap_ir_data", ir_data, 32'h1000_0000);
`ifdef IFU_PERF_CNT_EN
    checkOutput("t6_discard_count", 32'(discard_count), 32'd1);
    checkOutput("t6_fetch_count", fetch_count, 32'd1);
`endif
    endTest("t6");

    // Sixteen back-to-back handshakes at full rate.
    doReset();
    for (int i = 0; i < 17; i++) req_q.push_back(PC_W'(i));
    for (int i = 0; i < 16; i++) pushIr(32'h1000_0000 + 32'(i), PC_W'(i));
    ir_ready = 1'b1;
    waitHs(16, "t7_hs_timeout");
    ir_ready = 1'b0;
    checkOutput("t7_span", 32'(hs_cyc[15] - hs_cyc[0]), 32'd45);
    waitValid("t7_valid_timeout");
    checkOutput("t7_park_pc", 32'(ir_pc), 32'd16);
`ifdef IFU_PERF_CNT_EN
    checkOutput("t7_fetch_count", fetch_count, 32'd16);
`endif
    endTest("t7");

    tick();
    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
    $finish;
  end

endmodule
